// File: rtl/mcycle_ctrl_pkg.sv
// mcycle_ctrl_pkg: state codes, opcode classes, alu_src_b codes and control-word bit offsets
package mcycle_ctrl_pkg;
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  localparam logic [1:0] CLS_BR = 2'b00;
  localparam logic [1:0] CLS_ALU = 2'b01;
  localparam logic [1:0] CLS_LS = 2'b10;
  localparam logic [1:0] CLS_IMM = 2'b11;
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  // offsets above the alu_op field
  localparam int B_PC = 9;
  localparam int B_IR = 8;
  localparam int B_MR = 7;
  localparam int B_MW = 6;
  localparam int B_RW = 5;
  localparam int B_SA = 4;
  localparam int B_SB = 2;
  localparam int B_M2R = 1;
  localparam int B_BR = 0;
endpackage

// File: rtl/mcycle_mem_wait.sv
// mcycle_mem_wait: per-access wait counter; expired when MEM_TIMEOUT waits elapsed and still not ready
module mcycle_mem_wait #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic ready,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk)
    if (reset || clear) cnt <= '0;
    else if (!ready) cnt <= cnt + 8'd1;
  assign expired = !ready && cnt == 8'(MEM_TIMEOUT);
endmodule

// File: rtl/mcycle_controller.sv
// mcycle_controller: multi-cycle CPU control FSM with registered control word.
// Define CTRL_PERF_EN to build the retired-instruction counter.
module mcycle_controller
  import mcycle_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int MEM_TIMEOUT = 15,
  localparam int AF_W = OP_W - 2,
  localparam int CTRL_W = 10 + AF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   opcode,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [2:0]        state_out,
  output logic              instr_done,
  output logic              mem_fault,
  output logic [31:0]       perf_count
);
  state_t state, next;
  logic [OP_W-1:0] op_q;
  logic [CTRL_W-1:0] ctrl_d;
  logic done_d, fault_d, expired, clear;
  logic [1:0] cls;
  assign cls = op_q[OP_W-1 -: 2];
  assign clear = next != state || expired;
  mcycle_mem_wait #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait (
    .clk(clk), .reset(reset), .clear(clear), .ready(mem_ready), .expired(expired)
  );
  always_comb begin
    next = FETCH;
    ctrl_d = '0;
    done_d = 1'b0;
    fault_d = 1'b0;
    case (state)
      FETCH: begin
        ctrl_d[AF_W+B_MR] = !expired;
        fault_d = expired;
        if (mem_ready) begin
          ctrl_d[AF_W+B_PC] = 1'b1;
          ctrl_d[AF_W+B_IR] = 1'b1;
          ctrl_d[AF_W+B_SB +: 2] = SRCB_FOUR;
          next = DECODE;
        end
      end
      DECODE: next = EXEC;
      EXEC: begin
        ctrl_d[AF_W+B_SA] = 1'b1;
        ctrl_d[AF_W+B_SB +: 2] = (cls == CLS_LS || cls == CLS_IMM) ? SRCB_IMM : SRCB_REG;
        ctrl_d[AF_W+B_BR] = cls == CLS_BR;
        ctrl_d[AF_W-1:0] = cls == CLS_LS ? '0 : op_q[AF_W-1:0];
        done_d = cls == CLS_BR;
        if (cls == CLS_LS) next = MEM;
        else if (cls != CLS_BR) next = WB;
      end
      MEM: begin
        ctrl_d[AF_W+B_MR] = !op_q[0] && !expired;
        ctrl_d[AF_W+B_MW] = op_q[0] && !expired;
        fault_d = expired;
        done_d = op_q[0] && mem_ready;
        if (mem_ready) next = op_q[0] ? FETCH : WB;
        else if (!expired) next = MEM;
      end
      WB: begin
        ctrl_d[AF_W+B_RW] = 1'b1;
        ctrl_d[AF_W+B_M2R] = cls == CLS_LS;
        ctrl_d[AF_W-1:0] = cls == CLS_LS ? '0 : op_q[AF_W-1:0];
        done_d = 1'b1;
      end
      default: next = FETCH;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= FETCH;
      op_q <= '0;
      ctrl_out <= '0;
      instr_done <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      state <= next;
      ctrl_out <= ctrl_d;
      instr_done <= done_d;
      mem_fault <= fault_d;
      if (state == DECODE) op_q <= opcode;
    end
  assign state_out = state;
`ifdef CTRL_PERF_EN
  logic [31:0] perf_q;
  always_ff @(posedge clk)
    if (reset) perf_q <= '0;
    else if (done_d) perf_q <= perf_q + 32'd1;
  assign perf_count = perf_q;
`else
  assign perf_count = '0;
`endif
endmodule

// File: tb/tb_mcycle_controller.sv
// tb_mcycle_controller: random instruction streams against a per-instruction latency/outcome model.
module tb_mcycle_controller;
  localparam int T = 4;
  localparam int CW = 14;
`ifdef CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  typedef struct {
    logic fault;
    int len;
    logic [CW-1:0] ctrl;
  } exp_t;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = '0;
  logic [CW-1:0] ctrl_out;
  logic [2:0] state_out;
  logic instr_done, mem_fault;
  logic [31:0] perf_count;
  int checks = 0, errors = 0, cyc = 0, mbase = 0, ret = 0;
  exp_t sb[$];
  mcycle_controller #(.OP_W(6), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .ctrl_out(ctrl_out),
    .state_out(state_out), .instr_done(instr_done), .mem_fault(mem_fault), .perf_count(perf_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [CW-1:0] cw(input logic pc, ir, mr, mw, rw, sa, input logic [1:0] sb_, input logic m2r, br, input logic [3:0] aop);
    return {pc, ir, mr, mw, rw, sa, sb_, m2r, br, aop};
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", n, got, exp, cyc);
    end
  endtask
  task automatic step(input logic r);
    mem_ready = r;
    @(negedge clk);
  endtask
  task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
    exp_t e;
    logic [3:0] a;
    a = op[3:0];
    opcode = op;
    if (wf > T) begin
      e = '{1'b1, T + 1, '0};
      sb.push_back(e);
      repeat (T + 1) step(1'b0);
      return;
    end
    case (op[5:4])
      2'b00: e = '{1'b0, wf + 3, cw(0, 0, 0, 0, 0, 1, 2'b00, 0, 1, a)};
      2'b01: e = '{1'b0, wf + 4, cw(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, a)};
      2'b11: e = '{1'b0, wf + 4, cw(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, a)};
      default:
        if (wm > T) e = '{1'b1, wf + 4 + T, '0};
        else if (op[0]) e = '{1'b0, wf + wm + 4, cw(0, 0, 0, 1, 0, 0, 2'b00, 0, 0, 4'h0)};
        else e = '{1'b0, wf + wm + 5, cw(0, 0, 0, 0, 1, 0, 2'b00, 1, 0, 4'h0)};
    endcase
    sb.push_back(e);
    repeat (wf) step(1'b0);
    step(1'b1);
    chk("fetch_ctrl", 32'(ctrl_out), 32'(cw(1, 1, 1, 0, 0, 0, 2'b01, 0, 0, 4'h0)));
    chk("decode_state", 32'(state_out), 32'd1);
    step(1'($urandom_range(0, 1)));
    chk("decode_ctrl", 32'(ctrl_out), 32'd0);
    chk("exec_state", 32'(state_out), 32'd2);
    opcode = 6'($urandom);
    step(1'($urandom_range(0, 1)));
    if (op[5:4] == 2'b10) begin
      if (wm > T) repeat (T + 1) step(1'b0);
      else begin
        repeat (wm) step(1'b0);
        step(1'b1);
        if (!op[0]) step(1'($urandom_range(0, 1)));
      end
    end else if (op[5:4] != 2'b00) step(1'($urandom_range(0, 1)));
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (instr_done || mem_fault)) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse done=%b fault=%b expected none", instr_done, mem_fault);
        end else begin
          e = sb.pop_front();
          chk("pulse_kind", {30'd0, instr_done, mem_fault}, e.fault ? 32'd1 : 32'd2);
          chk("latency", 32'(cyc - mbase), 32'(e.len));
          chk("final_ctrl", 32'(ctrl_out), 32'(e.ctrl));
          chk("next_fetch", 32'(state_out), 32'd0);
          if (!e.fault) ret++;
          chk("perf_count", perf_count, PERF ? 32'(ret) : 32'd0);
        end
        mbase = cyc;
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ctrl", 32'(ctrl_out), 32'd0);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_perf", perf_count, 32'd0);
    chk("rst_pulses", {30'd0, instr_done, mem_fault}, 32'd0);
    reset = 1'b0;
    mbase = cyc;
    run_instr(6'b010011, 0, 0);
    run_instr(6'b100000, 0, 3);
    run_instr(6'b100001, 0, 5);
    run_instr(6'b000101, 0, 0);
    run_instr(6'b110111, T, 0);
    run_instr(6'b100000, 1, T);
    run_instr(6'b000000, T + 1, 0);
    run_instr(6'b100001, 2, T);
    for (int i = 0; i < 80; i++)
      run_instr(6'($urandom), int'($urandom_range(0, 3)) + ($urandom_range(0, 5) == 0 ? 2 : 0), int'($urandom_range(0, T + 1)));
    repeat (3) step(1'b0);
    opcode = 6'b100001;
    step(1'b1);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    step(1'b0);
    reset = 1'b1;
    step(1'b0);
    chk("mem_rst_state", 32'(state_out), 32'd0);
    chk("mem_rst_ctrl", 32'(ctrl_out), 32'd0);
    chk("mem_rst_perf", perf_count, 32'd0);
    chk("mem_rst_pulses", {30'd0, instr_done, mem_fault}, 32'd0);
    reset = 1'b0;
    step(1'b1);
    chk("post_rst_fetch", 32'(ctrl_out), 32'(cw(1, 1, 1, 0, 0, 0, 2'b01, 0, 0, 4'h0)));
    chk("post_rst_state", 32'(state_out), 32'd1);
    repeat (2) step(1'b0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcycle_controller.md
MCYCLE_CONTROLLER -- requirements
Module: mcycle_controller

Interface
REQ-001 SHALL have parameter OP_W, default 6, opcode width (min 3); ALU field width AF_W = OP_W-2.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum wait cycles per memory access (1..255).
REQ-003 SHALL have derived localparam CTRL_W = 10 + AF_W, control word width.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 opcode  in  OP_W  instruction opcode; bits [OP_W-1:OP_W-2] = class, bits [AF_W-1:0] = ALU field.
REQ-007 mem_ready  in  1  memory handshake; access completes in any cycle it is high.
REQ-008 ctrl_out  out  CTRL_W  registered control word: [CTRL_W-1] pc_write, then ir_write, mem_read, mem_write, reg_write, alu_src_a, alu_src_b[1:0], mem_to_reg, branch, then alu_op[AF_W-1:0].
REQ-009 state_out  out  3  current state encoding.
REQ-010 instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
REQ-011 mem_fault  out  1  one-cycle pulse on a memory timeout.
REQ-012 perf_count  out  32  retired-instruction count (see Configuration).

Function
REQ-013 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next edge.
REQ-014 Classes: 00 branch, 01 register ALU, 10 load (opcode[0]=0) or store (opcode[0]=1), 11 immediate ALU.
REQ-015 FETCH SHALL assert mem_read; on mem_ready=1 SHALL also assert ir_write and pc_write, with alu_src_b=01, and go to DECODE.
REQ-016 DECODE SHALL latch opcode into op_q and go to EXEC; opcode changes after DECODE SHALL be ignored until the next DECODE.
REQ-017 EXEC, branch: SHALL assert branch, alu_src_a=1, alu_op=op_q field and instr_done, then go to FETCH.
REQ-018 EXEC, ALU classes: SHALL assert alu_src_a=1, alu_op=op_q field and alu_src_b=00 (reg) or 10 (imm), then go to WB.
REQ-019 EXEC, load/store: SHALL assert alu_src_a=1 and alu_src_b=10 (address add), then go to MEM.
REQ-020 MEM SHALL hold mem_read (load) or mem_write (store) until mem_ready; then load goes to WB, and store pulses instr_done and goes to FETCH.
REQ-021 WB SHALL assert reg_write, with mem_to_reg=1 for loads only, pulse instr_done, and go to FETCH.
REQ-022 Latency with mem_ready held high: branch 3, store 4, ALU 4, load 5 cycles.
REQ-023 Wait counter (8 bit) SHALL clear on entering FETCH/MEM and increment each cycle mem_ready=0; at MEM_TIMEOUT it SHALL pulse mem_fault, deassert memory strobes and go to FETCH without instr_done.
REQ-024 mem_ready arriving in the same cycle the counter reaches MEM_TIMEOUT SHALL count as success, with no fault.
REQ-025 Unused control bits SHALL be 0 in every state.

Reset
REQ-026 reset=1 at a rising edge SHALL force FETCH and clear op_q, the wait counter, ctrl_out, instr_done, mem_fault and perf_count, overriding any access in flight.
REQ-027 The first cycle after reset release SHALL be FETCH with mem_read=1.

Configuration
REQ-028 With CTRL_PERF_EN defined, perf_count SHALL increment by 1 on each instr_done and wrap from 2^32-1 to 0.
REQ-029 Without CTRL_PERF_EN, perf_count SHALL be constant 0 and the counter SHALL not be synthesised.

Structure
REQ-030 Package mcycle_ctrl_pkg SHALL hold the state encodings, class codes, alu_src_b codes and ctrl_out bit-position constants.
REQ-031 Sub-module mcycle_mem_wait SHALL implement the wait counter and timeout (inputs: clear, ready; output: expired).

Verification
REQ-032 reset=1 for 1 edge, then mem_ready=1 -> state_out 0,1,...; ctrl_out=0 and perf_count=0 during reset.
REQ-033 opcode=6'b010011, mem_ready=1 -> sequence FETCH,DECODE,EXEC,WB; WB has reg_write=1, alu_op=4'b0011; instr_done on the 4th cycle.
REQ-034 opcode=6'b100000 (load), mem_ready low for 3 MEM cycles -> mem_read held 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
REQ-035 opcode=6'b100001, MEM_TIMEOUT=4, mem_ready=0 -> mem_fault pulses after 4 wait cycles, next state FETCH, no instr_done.
REQ-036 opcode=6'b000101 -> branch=1 in EXEC and instr_done on the 3rd cycle; opcode changed to 6'b110000 in EXEC -> ignored.
REQ-037 reset asserted during MEM of a store -> next state FETCH with mem_write=0; perf_count=0 (with CTRL_PERF_EN).
